sw_input_ctrl: RTL and testbench

- Avalon-MM slave controller for the board slide-switch input port. It synchronises and debounces the raw switch bus, and holds edge events in a capture register.
- It raises a maskable interrupt to the Nios II.
- It is a drop-in upgrade of the plain switch PIO: same 2-bit address space and same 1-cycle registered read timing, plus debounce and IRQ sequencing.

---
 rtl/sw_input_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sw_input_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_input_ctrl.sv
// Avalon-MM slide-switch input port: two-flop synchroniser, shared-counter debounce,
// edge capture with W1C clear and a maskable level interrupt. Registered 1-cycle reads.
module sw_input_ctrl #(
    parameter int unsigned WIDTH            = 18,
    parameter int unsigned DEBOUNCE_DEFAULT = 50000,
    parameter int unsigned EDGE_TYPE        = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_THRESH  = 2'd3;

    localparam logic [CNT_W-1:0] THRESH_RST = CNT_W'(DEBOUNCE_DEFAULT);

    // Synchroniser and debounce state
    logic [WIDTH-1:0]  sync1_q, sync1_d;
    logic [WIDTH-1:0]  sync2_q, sync2_d;
    logic [WIDTH-1:0]  prev_q,  prev_d;
    logic [WIDTH-1:0]  deb_q,   deb_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // Software-visible registers and outputs
    logic [WIDTH-1:0]  mask_q,   mask_d;
    logic [WIDTH-1:0]  cap_q,    cap_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              irq_q,    irq_d;

    // Combinational helpers
    logic              wr_en_c;
    logic              wr_mask_c;
    logic              wr_cap_c;
    logic              wr_thresh_c;
    logic              stable_c;
    logic              commit_c;
    logic [WIDTH-1:0]  rise_c;
    logic [WIDTH-1:0]  fall_c;
    logic [WIDTH-1:0]  edge_c;
    logic [WIDTH-1:0]  w1c_c;
    logic              unused_wd_c;

    assign unused_wd_c = ^writedata;

    // Bus write decode; DATA writes are ignored
    always_comb begin
        wr_en_c     = chipselect & ~write_n;
        wr_mask_c   = 1'b0;
        wr_cap_c    = 1'b0;
        wr_thresh_c = 1'b0;
        if (wr_en_c) begin
            case (address)
                ADDR_IRQMASK: wr_mask_c   = 1'b1;
                ADDR_EDGECAP: wr_cap_c    = 1'b1;
                ADDR_THRESH:  wr_thresh_c = 1'b1;
                default:      ;
            endcase
        end
    end

    // Synchroniser and one-cycle history
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Shared stability counter: any bit change restarts it, saturates at THRESH
    always_comb begin
        stable_c = (sync2_q == prev_q);
        cnt_d    = cnt_q;
        if (!stable_c) begin
            cnt_d = '0;
        end else if (cnt_q < thresh_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Whole-bus commit once the input has been stable for THRESH cycles
    always_comb begin
        commit_c = stable_c && (cnt_q >= thresh_q) && (sync2_q != deb_q);
        deb_d    = deb_q;
        if (commit_c) begin
            deb_d = sync2_q;
        end
    end

    // Edge detection on the committed value
    always_comb begin
        rise_c = ~deb_q & sync2_q;
        fall_c = deb_q & ~sync2_q;
        edge_c = '0;
        if (commit_c) begin
            case (EDGE_TYPE)
                0:       edge_c = rise_c;
                1:       edge_c = fall_c;
                default: edge_c = rise_c | fall_c;
            endcase
        end
    end

    // Register updates; a new edge wins over a simultaneous W1C
    always_comb begin
        w1c_c    = '0;
        mask_d   = mask_q;
        thresh_d = thresh_q;
        if (wr_cap_c) begin
            w1c_c = writedata[WIDTH-1:0];
        end
        if (wr_mask_c) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_thresh_c) begin
            thresh_d = writedata[CNT_W-1:0];
        end
        cap_d = (cap_q & ~w1c_c) | edge_c;
        irq_d = |(cap_d & mask_d);
    end

    // Read mux samples pre-update register values every cycle
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:    rdata_d = DATA_W'(deb_q);
            ADDR_IRQMASK: rdata_d = DATA_W'(mask_q);
            ADDR_EDGECAP: rdata_d = DATA_W'(cap_q);
            ADDR_THRESH:  rdata_d = DATA_W'(thresh_q);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            thresh_q <= THRESH_RST;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            thresh_q <= thresh_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Self-checking bench for sw_input_ctrl: expected read data queued when the read is
// driven, popped and compared when readdata is produced one cycle later.
module tb_sw_input_ctrl;

    localparam int unsigned WIDTH = 18;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int unsigned total;
    int unsigned bad;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    sw_input_ctrl #(
        .WIDTH            (WIDTH),
        .DEBOUNCE_DEFAULT (50000),
        .EDGE_TYPE        (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Queue an expectation for the current address, then compare after the next edge
    task automatic step_rd(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        chk(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        address = addr;
        step_rd(tag, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        idle(3);
        reset_n = 1'b1;

        // Reset values
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0, "rst_mask");
        rd(2'd2, 32'h0, "rst_cap");
        rd(2'd3, 32'h0000C350, "rst_thresh");

        // THRESH=4: debounced updates at E8, visible on readdata at E9
        wr(2'd3, 32'd4);
        rd(2'd3, 32'd4, "thresh4");
        address = 2'd0;
        in_port = 18'h00005;
        for (int k = 1; k <= 9; k++) begin
            step_rd($sformatf("lat_e%0d", k), (k == 9) ? 32'h5 : 32'h0);
        end
        rd(2'd2, 32'h5, "cap_5");
        chk("irq_unmasked", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h3FFFF);
        rd(2'd2, 32'h0, "cap_clr");

        // 4-cycle glitch on bit 3 is never committed
        in_port = 18'h0000D;
        idle(4);
        in_port = 18'h00005;
        idle(15);
        rd(2'd0, 32'h5, "glitch_data");
        rd(2'd2, 32'h0, "glitch_cap");

        // 8-cycle pulse commits high, then low again
        in_port = 18'h0000D;
        idle(8);
        in_port = 18'h00005;
        rd(2'd0, 32'hD, "pulse_hi");
        idle(15);
        rd(2'd0, 32'h5, "pulse_lo");
        rd(2'd2, 32'h8, "pulse_cap");
        wr(2'd2, 32'h8);
        rd(2'd2, 32'h0, "pulse_clr");

        // Masked bit 2 raises irq with the commit; W1C drops it
        in_port = 18'h00000;
        idle(20);
        wr(2'd2, 32'h3FFFF);
        rd(2'd2, 32'h0, "pre_irq_cap");
        wr(2'd1, 32'h4);
        rd(2'd1, 32'h4, "mask4");
        chk("irq_mask_only", {31'd0, irq}, 32'd0);
        in_port = 18'h00004;
        idle(7);
        chk("irq_before_commit", {31'd0, irq}, 32'd0);
        idle(1);
        chk("irq_at_commit", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h4);
        chk("irq_after_w1c", {31'd0, irq}, 32'd0);

        // Unmasked bit 0 edge: captured, no irq
        in_port = 18'h00005;
        idle(20);
        rd(2'd2, 32'h1, "cap_bit0");
        chk("irq_bit0", {31'd0, irq}, 32'd0);

        // Same-cycle W1C and new edge on bit 1: set wins
        wr(2'd1, 32'h6);
        in_port = 18'h00007;
        idle(20);
        chk("irq_bit1", {31'd0, irq}, 32'd1);
        in_port = 18'h00005;
        idle(7);
        wr(2'd2, 32'h2);
        chk("irq_set_wins", {31'd0, irq}, 32'd1);
        rd(2'd2, 32'h3, "cap_set_wins");
        rd(2'd0, 32'h5, "data_set_wins");

        // Fill EDGECAP, then reset during an active count
        in_port = 18'h00000;
        idle(20);
        in_port = 18'h3FFFF;
        idle(20);
        rd(2'd2, 32'h3FFFF, "cap_full");
        in_port = 18'h00000;
        idle(5);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        chk("rst2_rdata", readdata, 32'h0);
        rd(2'd3, 32'h0000C350, "rst2_thresh");
        rd(2'd1, 32'h0, "rst2_mask");
        idle(20);
        rd(2'd2, 32'h0, "rst2_cap");
        rd(2'd0, 32'h0, "rst2_data");
        chk("rst2_irq_late", {31'd0, irq}, 32'd0);

        // THRESH=0: commit at E4, readdata at E5
        wr(2'd3, 32'd0);
        address = 2'd0;
        in_port = 18'h0002A;
        for (int k = 1; k <= 5; k++) begin
            step_rd($sformatf("t0_e%0d", k), (k == 5) ? 32'h2A : 32'h0);
        end
        rd(2'd2, 32'h2A, "t0_cap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
